aes_round_sequencer: RTL and testbench
======================================

# aes_round_sequencer

Sequences one 128-bit cipher block through the external AES round datapath: accepts a block over a valid/ready handshake and issues NR+1 round operations (initial AddRoundKey, NR-1 full rounds, final round without MixColumns). It keeps the running state register and presents the finished block over a second valid/ready handshake. It sits between the block-level I/O and the combinational/multi-cycle round datapath, which matrixifies and dematrixifies internally.

## Interface
Parameters:
- NR, 10: number of cipher rounds. Legal values are 10, 12 and 14.
- TIMEOUT, 64: maximum cycles spent waiting for rnd_done before the operation is abandoned.

Ports:
- clk  input  1  sole clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- key_valid  input  1  key schedule for current key is ready.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can be accepted.
- in_data  input  128  plaintext block.
- out_valid  output  1  out_data holds a finished block.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  128  ciphertext block.
- rnd_start  output  1  one-cycle pulse that launches one round operation.
- rnd_num  output  4  round index 0..NR for the operation in flight.
- rnd_final  output  1  high when rnd_num == NR (datapath skips MixColumns).
- rnd_state  output  128  state fed to the datapath.
- rnd_done  input  1  datapath result valid.
- rnd_result  input  128  datapath output state.
- abort  input  1  synchronous cancel of the current block.
- busy  output  1  high in any state other than IDLE.
- err  output  1  one-cycle pulse on timeout.

Byte layout on every 128-bit bus: bits [8*(4c+r)+7 : 8*(4c+r)] hold state row r, column c. The block never reorders bytes.

## Operation
- State register `st` (128 bits). rnd_state = st. out_data = st.
- FSM states:
  - IDLE
    - in_ready = key_valid.
    - On in_valid & in_ready: st <= in_data, rnd_num <= 0, go to START.
  - START
    - rnd_start = 1 for exactly this cycle, then go to WAIT.
    - Clear the timeout counter.
  - WAIT
    - On rnd_done and rnd_num < NR: st <= rnd_result, rnd_num <= rnd_num + 1, go to START.
    - On rnd_done and rnd_num == NR: st <= rnd_result, go to DONE.
    - Otherwise increment the timeout counter. When it reaches TIMEOUT: pulse err, go to IDLE, leave st unchanged.
  - DONE
    - out_valid = 1.
    - On out_ready: go to IDLE. in_ready is not asserted in that same cycle.
- rnd_final = (rnd_num == NR), decoded combinationally.
- rnd_done is ignored outside WAIT. This includes a rnd_done in the START cycle.
- abort, in any state: next state is IDLE, out_valid is dropped, no err pulse. abort takes priority over rnd_done, out_ready and the timeout.
- key_valid is sampled only in IDLE. Deasserting it mid-block has no effect.
- in_ready is low in every state except IDLE.

## Timing
- Reset values: state IDLE, st = 0, rnd_num = 0, timeout counter = 0.
- Outputs under reset: out_valid = 0, out_data = 0, rnd_start = 0, rnd_final = 0, busy = 0, err = 0. in_ready = key_valid.
- Reset asserted mid-operation: IDLE next cycle, same values as above.
- Accept at edge T:
  - START of round k in cycle T+1+2k.
  - With a 1-cycle datapath, rnd_done in cycle T+2+2k.
  - out_valid first high at T+1+2(NR+1). For NR=10 that is T+23.
- Each additional datapath wait cycle delays every later event by one cycle.
- Back-to-back throughput: if out_ready is high when DONE is entered, the next block can be accepted one cycle after DONE (in IDLE).
- out_data is stable while out_valid is high and out_ready is low.

## Test plan
- Known-answer test: NR=10, key_valid=1, in_data=00112233445566778899aabbccddeeff, FIPS-197 key 000102…0f, reference datapath with 1-cycle latency -> out_valid at T+23, out_data=69c4e0d86a7b0430d8cdb78070b4c55a.
- Sequencing: a datapath model with random 1-5 cycle latency -> rnd_num sequence 0,1,…,10, exactly 11 rnd_start pulses, rnd_final high only on round 10, same ciphertext as the known-answer test.
- Backpressure: hold out_ready=0 for 20 cycles -> out_valid and out_data held constant, in_ready=0 throughout; release -> IDLE next cycle.
- Timeout: the datapath never asserts rnd_done -> err pulse after 64 WAIT cycles, busy falls, no out_valid.
- abort in WAIT of round 5, with rnd_done asserted in the same cycle -> IDLE next cycle, st not updated, no err.
- Reset in DONE -> out_valid=0, out_data=0 next cycle. key_valid=0 in IDLE with in_valid=1 -> in_ready=0, no accept.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// Round sequencer for one 128-bit AES block: loads a block, launches NR+1 round
// operations on the external datapath, and holds the result until it is consumed.
module aes_round_sequencer #(
  parameter int NR      = 10,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_valid,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         rnd_start,
  output logic [3:0]   rnd_num,
  output logic         rnd_final,
  output logic [127:0] rnd_state,
  input  logic         rnd_done,
  input  logic [127:0] rnd_result,
  input  logic         abort,
  output logic         busy,
  output logic         err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int          TW       = $clog2(TIMEOUT + 1);
  localparam logic [3:0]  NR_L     = 4'(NR);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [127:0]  st_q, st_d;
  logic [3:0]    rnd_num_q, rnd_num_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          timeout;

  always_comb begin
    // NOTE: every variable gets a default first, so no path through the case can infer a latch.
    state_d   = state_q;
    st_d      = st_q;
    rnd_num_d = rnd_num_q;
    tmo_d     = tmo_q;
    timeout   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid && key_valid) begin
          st_d      = in_data;
          rnd_num_d = 4'd0;
          state_d   = S_START;
        end
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rnd_done) begin
          st_d = rnd_result;
          if (rnd_num_q == NR_L) begin
            state_d = S_DONE;
          end else begin
            rnd_num_d = rnd_num_q + 4'd1;
            state_d   = S_START;
          end
        end else if (tmo_q == TMO_LAST) begin
          // The TIMEOUT-th empty WAIT cycle abandons the block; st keeps its last value.
          timeout = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Cancel wins over every other event and leaves the data registers untouched.
    if (abort) begin
      state_d   = S_IDLE;
      st_d      = st_q;
      rnd_num_d = rnd_num_q;
      tmo_d     = tmo_q;
      timeout   = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      st_q      <= '0;
      rnd_num_q <= 4'd0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      st_q      <= st_d;
      rnd_num_q <= rnd_num_d;
      tmo_q     <= tmo_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && key_valid;
  assign out_valid = (state_q == S_DONE);
  assign out_data  = st_q;
  assign rnd_start = (state_q == S_START);
  assign rnd_num   = rnd_num_q;
  assign rnd_final = (rnd_num_q == NR_L);
  assign rnd_state = st_q;
  assign busy      = (state_q != S_IDLE);
  assign err       = timeout;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: an AES-128 round model stands in for the
// external datapath; expected ciphertext is the FIPS-197 appendix C.1 vector.
module tb_aes_round_sequencer;

  localparam int NR      = 10;
  localparam int TIMEOUT = 64;

  logic         clk = 1'b0;
  logic         reset, key_valid, in_valid, in_ready, out_valid, out_ready;
  logic         rnd_start, rnd_final, rnd_done, abort, busy, err;
  logic [127:0] in_data, out_data, rnd_state, rnd_result;
  logic [3:0]   rnd_num;

  always #5 clk = ~clk;

  aes_round_sequencer #(.NR(NR), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .rnd_start  (rnd_start),
    .rnd_num    (rnd_num),
    .rnd_final  (rnd_final),
    .rnd_state  (rnd_state),
    .rnd_done   (rnd_done),
    .rnd_result (rnd_result),
    .abort      (abort),
    .busy       (busy),
    .err        (err)
  );

  // Datapath: either the AES model (dp_auto) or hand-driven done/result.
  logic         dp_auto, dp_rand, dp_done_m, man_done;
  int           dp_lat;
  logic [127:0] dp_res_m, man_result;
  assign rnd_done   = dp_auto ? dp_done_m : man_done;
  assign rnd_result = dp_auto ? dp_res_m  : man_result;

  int errors = 0;
  int checks = 0;

  logic [7:0]  sbox_t [256];
  logic [31:0] w [44];
  logic [127:0] kat_in, kat_out;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [7:0] r = 8'((b << k) | (b >> (8 - k)));
    return r;
  endfunction

  function automatic logic [127:0] byterev(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = x[8*(15-i) +: 8];
    return r;
  endfunction

  function automatic logic [127:0] rk(input int k);
    logic [7:0] b = 8'(16 + k);
    return {16{b}};
  endfunction

  // One AES-128 round; bus byte 4c+r is state row r, column c.
  function automatic logic [127:0] aes_round(input logic [127:0] s_in, input int n);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) s[i] = s_in[8*i +: 8];
    if (n != 0) begin
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          t[4*c+rr] = sbox_t[s[4*((c+rr)%4)+rr]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (n < NR) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
    end
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        s[4*c+rr] = s[4*c+rr] ^ w[4*n+c][8*(3-rr) +: 8];
    for (int i = 0; i < 16; i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  task automatic init_tables();
    logic [7:0] inv, b, rcon;
    logic [31:0] tmp;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox_t[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    end
    for (int i = 0; i < 4; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rcon;
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ tmp;
    end
  endtask

  // Datapath model: result appears dp_lat (or random 1..5) cycles after the START cycle.
  initial begin
    logic         pending;
    int           wcnt;
    logic [127:0] pres;
    pending = 1'b0; wcnt = 0; pres = '0;
    dp_done_m = 1'b0; dp_res_m = '0;
    forever begin
      @(posedge clk); #1;
      dp_done_m = 1'b0;
      if (reset) pending = 1'b0;
      if (pending) begin
        if (wcnt == 0) begin
          dp_done_m = 1'b1;
          dp_res_m  = pres;
          pending   = 1'b0;
        end else begin
          wcnt--;
        end
      end
      if (rnd_start && dp_auto) begin
        pending = 1'b1;
        pres    = aes_round(rnd_state, int'(rnd_num));
        wcnt    = dp_rand ? int'($urandom_range(1, 5)) - 1 : dp_lat - 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Accepts one block and runs until out_valid; cycle 1 is the START cycle after the accept edge.
  task automatic run_block(input logic [127:0] d, output int cyc, output int nstart,
                           output int seq_err);
    in_data = d; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 0; nstart = 0; seq_err = 0;
    while (cyc < 1000) begin
      cyc++;
      if (rnd_start) begin
        if (rnd_num !== 4'(nstart) || rnd_final !== (nstart == NR)) seq_err++;
        nstart++;
      end
      if (out_valid) break;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; key_valid = 1'b1;
    tick(); tick();
    checks++; if ({out_valid, rnd_start, rnd_final, busy, err} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000", {out_valid, rnd_start, rnd_final, busy, err});
    end
    checks++; if (out_data !== 128'h0 || rnd_num !== 4'd0) begin
      errors++; $display("FAIL reset_data: got out_data=%h rnd_num=%0d expected 0/0", out_data, rnd_num);
    end
    checks++; if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    reset = 1'b0;
    tick();
    key_valid = 1'b0; #1;
    checks++; if (in_ready !== 1'b0) begin
      errors++; $display("FAIL idle_in_ready_nokey: got %b expected 0", in_ready);
    end
    key_valid = 1'b1; #1;
  endtask

  task automatic test_kat();
    int cyc, ns, se;
    dp_auto = 1'b1; dp_rand = 1'b0; dp_lat = 1;
    run_block(kat_in, cyc, ns, se);
    checks++; if (cyc !== 23) begin
      errors++; $display("FAIL kat_latency: got %0d expected 23", cyc);
    end
    checks++; if (out_data !== kat_out) begin
      errors++; $display("FAIL kat_data: got %h expected %h", out_data, kat_out);
    end
    checks++; if (ns !== NR + 1 || se !== 0) begin
      errors++; $display("FAIL kat_seq: got starts=%0d seq_err=%0d expected %0d/0", ns, se, NR + 1);
    end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL done_in_ready: got in_ready=%b busy=%b expected 0/1", in_ready, busy);
    end
    tick();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL done_release: got ov=%b busy=%b ir=%b expected 0/0/1", out_valid, busy, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random_latency();
    int cyc, ns, se;
    dp_rand = 1'b1;
    run_block(kat_in, cyc, ns, se);
    checks++; if (out_valid !== 1'b1 || cyc < 23) begin
      errors++; $display("FAIL rand_complete: got ov=%b cyc=%0d expected 1/>=23", out_valid, cyc);
    end
    checks++; if (ns !== NR + 1 || se !== 0) begin
      errors++; $display("FAIL rand_seq: got starts=%0d seq_err=%0d expected %0d/0", ns, se, NR + 1);
    end
    checks++; if (out_data !== kat_out) begin
      errors++; $display("FAIL rand_data: got %h expected %h", out_data, kat_out);
    end
    dp_rand = 1'b0;
  endtask

  task automatic test_backpressure();
    int bad;
    // The DUT is left in DONE by test_random_latency with out_ready low.
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid !== 1'b1 || out_data !== kat_out || in_ready !== 1'b0) bad++;
      tick();
    end
    checks++; if (bad !== 0) begin
      errors++; $display("FAIL bp_hold: got %0d bad cycles expected 0", bad);
    end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release: got ov=%b busy=%b expected 0/0", out_valid, busy);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc, ns, se;
    out_ready = 1'b1;
    run_block(kat_in, cyc, ns, se);
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got ir=%b ov=%b expected 1/0", in_ready, out_valid);
    end
    run_block(kat_in, cyc, ns, se);
    checks++; if (cyc !== 23 || out_data !== kat_out) begin
      errors++; $display("FAIL b2b_second: got cyc=%0d data=%h expected 23/%h", cyc, out_data, kat_out);
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int first_err, err_cnt, busy_low;
    logic ov;
    dp_auto = 1'b0; man_done = 1'b0;
    in_data = rk(7); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    first_err = -1; err_cnt = 0; busy_low = -1; ov = 1'b0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (err) begin err_cnt++; if (first_err < 0) first_err = cyc; end
      if (out_valid) ov = 1'b1;
      if (!busy && busy_low < 0) busy_low = cyc;
      tick();
    end
    checks++; if (first_err !== 65 || err_cnt !== 1) begin
      errors++; $display("FAIL tmo_err: got first=%0d count=%0d expected 65/1", first_err, err_cnt);
    end
    checks++; if (busy_low !== 66 || ov !== 1'b0) begin
      errors++; $display("FAIL tmo_busy: got busy_low=%0d ov=%b expected 66/0", busy_low, ov);
    end
    checks++; if (rnd_state !== rk(7)) begin
      errors++; $display("FAIL tmo_state: got %h expected %h", rnd_state, rk(7));
    end
  endtask

  task automatic test_abort();
    dp_auto = 1'b0;
    in_data = rk(9); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      if (k == 3) begin
        checks++; if (rnd_start !== 1'b1 || rnd_num !== 4'd3 || rnd_state !== rk(2)) begin
          errors++; $display("FAIL abort_round3: got start=%b num=%0d st=%h expected 1/3/%h",
                             rnd_start, rnd_num, rnd_state, rk(2));
        end
      end
      // A done during START must be ignored.
      if (k == 2) begin man_done = 1'b1; man_result = 128'hdead; end
      tick();
      man_done = 1'b1; man_result = rk(k); abort = (k == 5);
      #1;
      if (k == 5) begin
        checks++; if (err !== 1'b0 || busy !== 1'b1) begin
          errors++; $display("FAIL abort_cycle: got err=%b busy=%b expected 0/1", err, busy);
        end
      end
      tick();
      man_done = 1'b0; abort = 1'b0;
    end
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got busy=%b ov=%b err=%b expected 0/0/0", busy, out_valid, err);
    end
    checks++; if (rnd_state !== rk(4)) begin
      errors++; $display("FAIL abort_state: got %h expected %h", rnd_state, rk(4));
    end
    dp_auto = 1'b1;
  endtask

  task automatic test_reset_in_done();
    int cyc, ns, se;
    run_block(kat_in, cyc, ns, se);
    checks++; if (out_valid !== 1'b1) begin
      errors++; $display("FAIL rdone_reach: got ov=%b expected 1", out_valid);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_data !== 128'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL rdone_reset: got ov=%b data=%h busy=%b expected 0/0/0", out_valid, out_data, busy);
    end
    key_valid = 1'b0; in_valid = 1'b1; in_data = kat_in; #1;
    checks++; if (in_ready !== 1'b0) begin
      errors++; $display("FAIL nokey_ready: got %b expected 0", in_ready);
    end
    tick();
    checks++; if (busy !== 1'b0 || rnd_start !== 1'b0) begin
      errors++; $display("FAIL nokey_accept: got busy=%b start=%b expected 0/0", busy, rnd_start);
    end
    in_valid = 1'b0; key_valid = 1'b1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; key_valid = 1'b1; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; abort = 1'b0;
    dp_auto = 1'b1; dp_rand = 1'b0; dp_lat = 1;
    man_done = 1'b0; man_result = '0;
    init_tables();
    kat_in  = byterev(128'h00112233445566778899aabbccddeeff);
    kat_out = byterev(128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    test_reset();
    test_kat();
    test_random_latency();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_abort();
    test_reset_in_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
